// File: rtl/player_ctrl.sv
// Bomberman player controller: button-driven stepping with wall/tile blocking,
// beam/enemy hit detection, lives with respawn and invulnerability, sprite-area flag.
module player_ctrl #(
   parameter int MIN_X         = 143,
   parameter int MAX_X         = 784,
   parameter int MIN_Y         = 34,
   parameter int MAX_Y         = 516,
   parameter int SPR_W         = 16,
   parameter int SPR_H         = 16,
   parameter int START_X       = 143,
   parameter int START_Y       = 34,
   parameter int STEP_PERIOD   = 1400000,
   parameter int CNT_W         = 21,
   parameter int BEAM_REACH    = 48,
   parameter int BEAM_W        = 16,
   parameter int LIVES         = 3,
   parameter int INVULN_CYCLES = 100000000,
   parameter int BLINK_BIT     = 22
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       L,
   input  logic       R,
   input  logic       U,
   input  logic       D,
   input  logic [3:0] blocked,
   input  logic [9:0] e_x,
   input  logic [9:0] e_y,
   input  logic       explosion_SCEN,
   input  logic       enemy_hit,
   input  logic [9:0] v_x,
   input  logic [9:0] v_y,
   output logic [9:0] p_x,
   output logic [9:0] p_y,
   output logic [1:0] facing,
   output logic       moving,
   output logic [2:0] lives,
   output logic       invuln,
   output logic       hit_pulse,
   output logic       game_over,
   output logic       player_on
);

   localparam int IC_CLOG = $clog2(INVULN_CYCLES + 1);
   localparam int IC_W    = (IC_CLOG > BLINK_BIT) ? IC_CLOG : BLINK_BIT + 1;

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_PERIOD - 1);
   localparam logic [IC_W-1:0]  IC_ZERO   = {IC_W{1'b0}};
   localparam logic [IC_W-1:0]  IC_ONE    = IC_W'(1);
   localparam logic [IC_W-1:0]  IC_LOAD   = IC_W'(INVULN_CYCLES);
   localparam logic [9:0]  MIN_X_V   = 10'(MIN_X);
   localparam logic [9:0]  MIN_Y_V   = 10'(MIN_Y);
   localparam logic [9:0]  RIGHT_LIM = 10'(MAX_X - SPR_W);
   localparam logic [9:0]  DOWN_LIM  = 10'(MAX_Y - SPR_H);
   localparam logic [9:0]  START_X_V = 10'(START_X);
   localparam logic [9:0]  START_Y_V = 10'(START_Y);
   localparam logic [2:0]  LIVES_V   = 3'(LIVES);
   localparam logic [11:0] SW1       = 12'(SPR_W - 1);
   localparam logic [11:0] SH1       = 12'(SPR_H - 1);
   localparam logic [11:0] REACH     = 12'(BEAM_REACH);
   localparam logic [11:0] BW1       = 12'(BEAM_W - 1);
   localparam logic [11:0] BEAM_END  = 12'(BEAM_W + BEAM_REACH - 1);

   typedef enum logic [0:0] {M_IDLE, M_MOVE} move_state_t;
   typedef enum logic [1:0] {L_ALIVE, L_INVULN, L_DEAD} life_state_t;

   move_state_t      m_state_r, m_state_s;
   life_state_t      l_state_r, l_state_s;
   logic [1:0]       dir_r, dir_s, facing_s, btn_dir_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [IC_W-1:0]  ic_r, ic_s;
   logic [9:0]       px_s, py_s;
   logic [2:0]       lives_s;
   logic             hit_pulse_s, game_over_s, step_s, step_ok_s;
   logic [3:0]       btn_s;
   logic             one_hot_s, h_ov_s, v_ov_s, hit_s;
   logic [11:0]      px12_s, py12_s, ex12_s, ey12_s, vx12_s, vy12_s;

   assign btn_s     = {D, U, R, L};
   assign one_hot_s = (btn_s != 4'b0000) && ((btn_s & (btn_s - 4'b0001)) == 4'b0000);

   assign px12_s = {2'b00, p_x};
   assign py12_s = {2'b00, p_y};
   assign ex12_s = {2'b00, e_x};
   assign ey12_s = {2'b00, e_y};
   assign vx12_s = {2'b00, v_x};
   assign vy12_s = {2'b00, v_y};

   // Beam subtractions are moved onto the sprite side so nothing underflows near the arena edge
   assign h_ov_s = (px12_s <= ex12_s + BEAM_END) && (ex12_s <= px12_s + SW1 + REACH) &&
                   (py12_s <= ey12_s + BW1)      && (ey12_s <= py12_s + SH1);
   assign v_ov_s = (px12_s <= ex12_s + BW1)      && (ex12_s <= px12_s + SW1) &&
                   (py12_s <= ey12_s + BEAM_END) && (ey12_s <= py12_s + SH1 + REACH);
   assign hit_s  = (explosion_SCEN && (h_ov_s || v_ov_s)) || enemy_hit;

   assign player_on = (vx12_s >= px12_s) && (vx12_s <= px12_s + SW1) &&
                      (vy12_s >= py12_s) && (vy12_s <= py12_s + SH1) &&
                      !(invuln && ic_r[BLINK_BIT]);

   // Encode the single pressed button; direction codes match the blocked[] bit order
   always_comb begin
      case (btn_s)
         4'b0001: btn_dir_s = 2'd0;
         4'b0010: btn_dir_s = 2'd1;
         4'b0100: btn_dir_s = 2'd2;
         4'b1000: btn_dir_s = 2'd3;
         default: btn_dir_s = 2'd0;
      endcase
   end

   // Arena-edge and blocking check for the latched direction
   always_comb begin
      case (dir_r)
         2'd0:    step_ok_s = !blocked[0] && (p_x > MIN_X_V);
         2'd1:    step_ok_s = !blocked[1] && (p_x < RIGHT_LIM);
         2'd2:    step_ok_s = !blocked[2] && (p_y > MIN_Y_V);
         2'd3:    step_ok_s = !blocked[3] && (p_y < DOWN_LIM);
         default: step_ok_s = 1'b0;
      endcase
   end

   // Next-state logic for movement and life FSMs; an accepted hit overrides any step
   always_comb begin
      m_state_s   = m_state_r;
      l_state_s   = l_state_r;
      dir_s       = dir_r;
      cnt_s       = cnt_r;
      facing_s    = facing;
      px_s        = p_x;
      py_s        = p_y;
      ic_s        = ic_r;
      lives_s     = lives;
      hit_pulse_s = 1'b0;
      game_over_s = game_over;
      step_s      = 1'b0;

      case (m_state_r)
         M_IDLE: begin
            if (one_hot_s) begin
               m_state_s = M_MOVE;
               dir_s     = btn_dir_s;
               facing_s  = btn_dir_s;
               cnt_s     = CNT_ZERO;
            end else begin
               m_state_s = M_IDLE;
            end
         end
         M_MOVE: begin
            if (btn_s != (4'b0001 << dir_r)) begin
               m_state_s = M_IDLE;
               cnt_s     = CNT_ZERO;
            end else if (cnt_r == STEP_LAST) begin
               cnt_s  = CNT_ZERO;
               step_s = 1'b1;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         default: m_state_s = M_IDLE;
      endcase

      if (step_s && step_ok_s && (l_state_r != L_DEAD)) begin
         case (dir_r)
            2'd0:    px_s = p_x - 10'd1;
            2'd1:    px_s = p_x + 10'd1;
            2'd2:    py_s = p_y - 10'd1;
            2'd3:    py_s = p_y + 10'd1;
            default: px_s = p_x;
         endcase
      end else begin
         px_s = p_x;
      end

      case (l_state_r)
         L_ALIVE: begin
            if (hit_s) begin
               hit_pulse_s = 1'b1;
               px_s        = START_X_V;
               py_s        = START_Y_V;
               m_state_s   = M_IDLE;
               cnt_s       = CNT_ZERO;
               if (lives > 3'd1) begin
                  lives_s   = lives - 3'd1;
                  l_state_s = L_INVULN;
                  ic_s      = IC_LOAD;
               end else begin
                  lives_s     = 3'd0;
                  game_over_s = 1'b1;
                  l_state_s   = L_DEAD;
               end
            end else begin
               l_state_s = L_ALIVE;
            end
         end
         L_INVULN: begin
            if (ic_r == IC_ZERO) begin
               l_state_s = L_ALIVE;
            end else begin
               ic_s = ic_r - IC_ONE;
            end
         end
         L_DEAD:  l_state_s = L_DEAD;
         default: l_state_s = L_ALIVE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         m_state_r <= M_IDLE;
         l_state_r <= L_ALIVE;
         dir_r     <= 2'd0;
         cnt_r     <= CNT_ZERO;
         ic_r      <= IC_ZERO;
         p_x       <= START_X_V;
         p_y       <= START_Y_V;
         facing    <= 2'b11;
         moving    <= 1'b0;
         lives     <= LIVES_V;
         invuln    <= 1'b0;
         hit_pulse <= 1'b0;
         game_over <= 1'b0;
      end else begin
         m_state_r <= m_state_s;
         l_state_r <= l_state_s;
         dir_r     <= dir_s;
         cnt_r     <= cnt_s;
         ic_r      <= ic_s;
         p_x       <= px_s;
         p_y       <= py_s;
         facing    <= facing_s;
         moving    <= (m_state_s == M_MOVE);
         lives     <= lives_s;
         invuln    <= (l_state_s == L_INVULN);
         hit_pulse <= hit_pulse_s;
         game_over <= game_over_s;
      end
   end

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them and matches every hit_pulse against expected hits.
module tb_player_ctrl;

   logic       clk = 1'b0;
   logic       reset, L, R, U, D, explosion_SCEN, enemy_hit;
   logic [3:0] blocked;
   logic [9:0] e_x, e_y, v_x, v_y, p_x, p_y;
   logic [1:0] facing;
   logic       moving, invuln, hit_pulse, game_over, player_on;
   logic [2:0] lives;

   always #5 clk = ~clk;

   player_ctrl #(.STEP_PERIOD(4), .CNT_W(3), .INVULN_CYCLES(10), .BLINK_BIT(2)) dut (
      .clk(clk), .reset(reset), .L(L), .R(R), .U(U), .D(D), .blocked(blocked),
      .e_x(e_x), .e_y(e_y), .explosion_SCEN(explosion_SCEN), .enemy_hit(enemy_hit),
      .v_x(v_x), .v_y(v_y), .p_x(p_x), .p_y(p_y), .facing(facing), .moving(moving),
      .lives(lives), .invuln(invuln), .hit_pulse(hit_pulse), .game_over(game_over),
      .player_on(player_on)
   );

   localparam int S_PX = 0, S_PY = 1, S_FACE = 2, S_MOV = 3, S_LIVES = 4,
                  S_INV = 5, S_GO = 6, S_ON = 7;

   typedef struct { int cyc; int sel; int val; } exp_t;
   exp_t expq[$];
   int   hitq[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t e;
   int   act;
   int   h;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int get_sig(int sel);
      case (sel)
         S_PX:    return int'(p_x);
         S_PY:    return int'(p_y);
         S_FACE:  return int'(facing);
         S_MOV:   return int'(moving);
         S_LIVES: return int'(lives);
         S_INV:   return int'(invuln);
         S_GO:    return int'(game_over);
         default: return int'(player_on);
      endcase
   endfunction

   function automatic string sname(int sel);
      case (sel)
         S_PX:    return "p_x";
         S_PY:    return "p_y";
         S_FACE:  return "facing";
         S_MOV:   return "moving";
         S_LIVES: return "lives";
         S_INV:   return "invuln";
         S_GO:    return "game_over";
         default: return "player_on";
      endcase
   endfunction

   // Monitor: compare queued expectations and account for every hit_pulse
   always @(negedge clk) begin
      while (expq.size() > 0 && expq[0].cyc <= cyc) begin
         e = expq.pop_front();
         act = get_sig(e.sel);
         checks++;
         if (e.cyc != cyc || act != e.val) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", sname(e.sel), cyc, act, e.val);
         end
      end
      while (hitq.size() > 0 && hitq[0] < cyc) begin
         h = hitq.pop_front();
         checks++;
         failures++;
         $display("FAIL hit_pulse_missing cyc=%0d actual=0 expected=1", h);
      end
      if (hit_pulse === 1'b1) begin
         checks++;
         if (hitq.size() == 0) begin
            failures++;
            $display("FAIL hit_pulse_unexpected cyc=%0d actual=1 expected=0", cyc);
         end else begin
            h = hitq.pop_front();
            if (h != cyc) begin
               failures++;
               $display("FAIL hit_pulse_cycle actual=%0d expected=%0d", cyc, h);
            end
         end
      end
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(int sel, int val);
      exp_t x;
      x.cyc = cyc;
      x.sel = sel;
      x.val = val;
      expq.push_back(x);
   endtask

   task automatic exp_hit();
      hitq.push_back(cyc + 1);
   endtask

   task automatic chk_reset_values();
      chk(S_PX, 143); chk(S_PY, 34); chk(S_FACE, 3); chk(S_MOV, 0);
      chk(S_LIVES, 3); chk(S_INV, 0); chk(S_GO, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; L = 1'b0; R = 1'b0; U = 1'b0; D = 1'b0; blocked = 4'b0000;
      e_x = 10'd0; e_y = 10'd0; explosion_SCEN = 1'b0; enemy_hit = 1'b0;
      v_x = 10'd143; v_y = 10'd34;
      tick(2);
      reset = 1'b0;
      chk_reset_values();
      chk(S_ON, 1);
      tick(1);
      v_x = 10'd158; v_y = 10'd49; chk(S_ON, 1);
      tick(1);
      v_x = 10'd159; v_y = 10'd34; chk(S_ON, 0);

      // left at the arena edge
      L = 1'b1; tick(1); chk(S_FACE, 0); chk(S_MOV, 1);
      tick(20); chk(S_PX, 143);
      L = 1'b0; tick(1); chk(S_MOV, 0);

      // right: first step STEP_PERIOD cycles after entry
      R = 1'b1; tick(4); chk(S_PX, 143); chk(S_FACE, 1);
      tick(1); chk(S_PX, 144);
      tick(4); chk(S_PX, 145);
      R = 1'b0; tick(1); chk(S_MOV, 0); chk(S_PX, 145);
      tick(5); chk(S_PX, 145);

      // left with blocked[0]
      blocked = 4'b0001; L = 1'b1; tick(1); chk(S_FACE, 0); chk(S_MOV, 1);
      tick(20); chk(S_PX, 145);
      L = 1'b0; blocked = 4'b0000; tick(1); chk(S_MOV, 0);

      // two buttons from IDLE
      R = 1'b1; U = 1'b1; tick(1); chk(S_MOV, 0);
      tick(3); chk(S_MOV, 0); chk(S_PY, 34);
      R = 1'b0; U = 1'b0; tick(1);

      // U pressed on the cycle a right step would land
      R = 1'b1; tick(4); chk(S_MOV, 1);
      U = 1'b1; tick(1); chk(S_MOV, 0); chk(S_PX, 145);
      tick(3); chk(S_PX, 145);
      R = 1'b0; U = 1'b0; tick(1);

      // walk to 200,100
      R = 1'b1; tick(221); chk(S_PX, 200);
      R = 1'b0; tick(1);
      D = 1'b1; tick(265); chk(S_PY, 100); chk(S_FACE, 3);
      D = 1'b0; tick(1); chk(S_MOV, 0);

      // beam boundary: last reaching e_x is 200+15+48=263
      e_x = 10'd264; e_y = 10'd100; explosion_SCEN = 1'b1; tick(1);
      explosion_SCEN = 1'b0; chk(S_LIVES, 3); chk(S_INV, 0);
      tick(1);
      e_x = 10'd263; explosion_SCEN = 1'b1; exp_hit(); tick(1);
      explosion_SCEN = 1'b0;
      chk(S_LIVES, 2); chk(S_PX, 143); chk(S_PY, 34); chk(S_INV, 1); chk(S_MOV, 0);
      tick(10); chk(S_INV, 1);
      tick(1); chk(S_INV, 0);

      // enemy hit on the same edge as a step
      R = 1'b1; tick(4);
      enemy_hit = 1'b1; exp_hit(); tick(1);
      enemy_hit = 1'b0;
      chk(S_PX, 143); chk(S_LIVES, 1); chk(S_INV, 1); chk(S_MOV, 0);
      tick(4);
      enemy_hit = 1'b1; tick(1);
      enemy_hit = 1'b0; chk(S_LIVES, 1); chk(S_PX, 144); chk(S_MOV, 1);
      R = 1'b0; L = 1'b1; tick(6); chk(S_PX, 143);
      L = 1'b0; tick(4);
      enemy_hit = 1'b1; exp_hit(); tick(1);
      enemy_hit = 1'b0;
      chk(S_LIVES, 0); chk(S_GO, 1); chk(S_INV, 0);

      // dead: buttons tracked, position frozen, hits ignored
      R = 1'b1; tick(12);
      chk(S_MOV, 1); chk(S_PX, 143); chk(S_GO, 1); chk(S_LIVES, 0);
      enemy_hit = 1'b1; tick(1);
      enemy_hit = 1'b0; tick(1); chk(S_GO, 1);

      // reset while moving
      reset = 1'b1; tick(1);
      chk_reset_values();
      reset = 1'b0; R = 1'b0; tick(2);

      checks++;
      if (expq.size() != 0 || hitq.size() != 0) begin
         failures++;
         $display("FAIL queues_drained actual=%0d/%0d expected=0/0", expq.size(), hitq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
